// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: Avalon-MM controlled LED sequencer.
// A prescaled step engine rotates or blinks a host-written seed pattern on
// the LED bank, optionally stopping on its own after one full sequence.
module led_seq_ctrl #(
    parameter int               LED_W         = 8,
    parameter int               CNT_W         = 24,
    parameter logic [LED_W-1:0] RESET_PATTERN = LED_W'(8'h01)
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    output logic [LED_W-1:0] leds_export,
    output logic             seq_done_irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PERIOD  = 2'd1;
    localparam logic [1:0] A_PATTERN = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    // Number of steps making up one complete oneshot sequence.
    localparam logic [8:0] ROT_LIMIT   = 9'(LED_W);
    localparam logic [8:0] BLINK_LIMIT = 9'd2;

    // CTRL bit positions
    localparam int C_RUN     = 0;
    localparam int C_MODE    = 1;
    localparam int C_DIR     = 2;
    localparam int C_ONESHOT = 3;

    state_t             r_state;
    logic [3:0]         r_ctrl;
    logic [CNT_W-1:0]   r_period;
    logic [LED_W-1:0]   r_pattern;
    logic [LED_W-1:0]   r_leds;
    logic [CNT_W-1:0]   r_presc;
    logic [7:0]         r_count;
    logic               r_done;
    logic               r_blink_on;   // next blink step shows the pattern
    logic [31:0]        r_readdata;

    logic [LED_W-1:0]   w_rot_left;
    logic [LED_W-1:0]   w_rot_right;
    logic [LED_W-1:0]   w_step_leds;
    logic               w_wr_ctrl;
    logic               w_wr_period;
    logic               w_wr_pattern;
    logic               w_wr_status;
    logic               w_stop_req;
    logic               w_step_due;
    logic               w_do_step;
    logic [8:0]         w_count_inc;
    logic [8:0]         w_limit;
    logic               w_final;
    logic [31:0]        w_status;
    logic               w_unused;

    // One-bit circular shifts built per LED bit.
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_rot
        assign w_rot_left[gi]  = r_leds[(gi + LED_W - 1) % LED_W];
        assign w_rot_right[gi] = r_leds[(gi + 1) % LED_W];
    end

    assign w_wr_ctrl    = avs_write && (avs_address == A_CTRL);
    assign w_wr_period  = avs_write && (avs_address == A_PERIOD);
    assign w_wr_pattern = avs_write && (avs_address == A_PATTERN);
    assign w_wr_status  = avs_write && (avs_address == A_STATUS);
    assign w_stop_req   = w_wr_ctrl && !avs_writedata[C_RUN];

    // A step is due when the prescaler has expired; a PATTERN write or a
    // stop request in the same cycle takes priority and cancels it.
    assign w_step_due   = (r_state == S_RUN) && (r_presc == '0);
    assign w_do_step    = w_step_due && !w_wr_pattern && !w_stop_req;

    assign w_count_inc  = {1'b0, r_count} + 9'd1;
    assign w_limit      = r_ctrl[C_MODE] ? BLINK_LIMIT : ROT_LIMIT;
    // ">=" so that enabling oneshot late in a long run still stops it.
    assign w_final      = r_ctrl[C_ONESHOT] && (w_count_inc >= w_limit);

    assign w_step_leds  = r_ctrl[C_MODE] ? (r_blink_on ? r_pattern : '0)
                        : (r_ctrl[C_DIR] ? w_rot_right : w_rot_left);

    assign w_status     = {r_count, 6'd0, r_done, (r_state == S_RUN), 16'(r_leds)};

    // Writedata bits above the widest register field are ignored.
    assign w_unused     = ^avs_writedata;

    // Register file, step engine and sequencer FSM.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= '0;
            r_period   <= '0;
            r_pattern  <= RESET_PATTERN;
            r_leds     <= RESET_PATTERN;
            r_presc    <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_blink_on <= 1'b0;
            r_readdata <= '0;
        end else begin
            // Read data reflects state before any same-cycle write.
            if (avs_read) begin
                case (avs_address)
                    A_CTRL:    r_readdata <= {28'd0, r_ctrl};
                    A_PERIOD:  r_readdata <= 32'(r_period);
                    A_PATTERN: r_readdata <= 32'(r_pattern);
                    default:   r_readdata <= w_status;
                endcase
            end

            if (w_wr_period) begin
                r_period <= avs_writedata[CNT_W-1:0];
            end

            // Prescaler counts down between steps; a stop freezes it.
            if (r_state == S_RUN && !w_step_due && !w_stop_req) begin
                r_presc <= r_presc - 1'b1;
            end

            if (w_wr_status) begin
                r_count <= '0;
                r_done  <= 1'b0;
                if (r_state == S_DONE) begin
                    r_state <= S_IDLE;
                end
            end

            if (w_do_step) begin
                r_leds  <= w_step_leds;
                r_presc <= r_period;
                r_count <= w_wr_status ? 8'd0 : w_count_inc[7:0];
                if (r_ctrl[C_MODE]) begin
                    r_blink_on <= !r_blink_on;
                end
                if (w_final) begin
                    r_state        <= S_DONE;
                    r_done         <= 1'b1;
                    r_ctrl[C_RUN]  <= 1'b0;
                end
            end

            if (w_wr_ctrl) begin
                if (avs_writedata[C_RUN]) begin
                    if (r_state == S_RUN) begin
                        // Live update: timing and count are left alone.
                        r_ctrl[3:1] <= avs_writedata[3:1];
                    end else begin
                        r_ctrl     <= avs_writedata[3:0];
                        r_state    <= S_RUN;
                        r_presc    <= r_period;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_blink_on <= 1'b0;
                    end
                end else begin
                    r_ctrl <= avs_writedata[3:0];
                    if (r_state == S_RUN) begin
                        r_state <= S_IDLE;
                    end
                end
            end

            // A new seed restarts the visible sequence and its timing.
            if (w_wr_pattern) begin
                r_pattern  <= avs_writedata[LED_W-1:0];
                r_leds     <= avs_writedata[LED_W-1:0];
                r_presc    <= r_period;
                r_blink_on <= 1'b0;
            end
        end
    end

    assign avs_readdata = r_readdata;
    assign leds_export  = r_leds;
    assign seq_done_irq = r_done;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed self-checking bench for led_seq_ctrl.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_led_seq_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [7:0]  leds_export;
    logic        seq_done_irq;

    int errors = 0;
    int checks = 0;

    led_seq_ctrl #(
        .LED_W(8),
        .CNT_W(24),
        .RESET_PATTERN(8'h01)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .leds_export(leds_export),
        .seq_done_irq(seq_done_irq)
    );

    always #5 clk_clk = ~clk_clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        cyc();
        avs_write     = 1'b0;
        $display("wr addr=%0d data=%h leds=%h", a, d, leds_export);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        cyc();
        avs_read    = 1'b0;
        d           = avs_readdata;
        $display("rd addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) cyc();
        reset_reset = 1'b0;
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL rst_leds got %h exp %h", leds_export, 8'h01); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata got %h exp %h", avs_readdata, 32'h0); end
        checks++; if (seq_done_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp %b", seq_done_irq, 1'b0); end
        rd(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp %h", d, 32'h0); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_period got %h exp %h", d, 32'h0); end
        rd(2'd2, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_pattern got %h exp %h", d, 32'h1); end
        rd(2'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_status got %h exp %h", d, 32'h1); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] d;
        avs_address   = 2'd1;
        avs_writedata = 32'd5;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        cyc();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        $display("rdwr addr=1 wdata=%h rdata=%h", 32'd5, avs_readdata);
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rdwr_old got %h exp %h", avs_readdata, 32'h0); end
        rd(2'd1, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL rdwr_new got %h exp %h", d, 32'h5); end
    endtask

    task automatic test_rotate_left();
        logic [31:0] d;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        repeat (3) cyc();
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL rot_early got %h exp %h", leds_export, 8'h01); end
        cyc();
        checks++; if (leds_export !== 8'h02) begin errors++; $display("FAIL rot_step1 got %h exp %h", leds_export, 8'h02); end
        repeat (4) cyc();
        checks++; if (leds_export !== 8'h04) begin errors++; $display("FAIL rot_step2 got %h exp %h", leds_export, 8'h04); end
        repeat (4) cyc();
        checks++; if (leds_export !== 8'h08) begin errors++; $display("FAIL rot_step3 got %h exp %h", leds_export, 8'h08); end
        repeat (20) cyc();
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL rot_wrap got %h exp %h", leds_export, 8'h01); end
        rd(2'd3, d);
        checks++; if (d !== 32'h08010001) begin errors++; $display("FAIL rot_status got %h exp %h", d, 32'h08010001); end
        wr(2'd0, 32'h0);
        repeat (6) cyc();
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL rot_hold got %h exp %h", leds_export, 8'h01); end
    endtask

    task automatic test_oneshot_right();
        logic [31:0] d;
        logic [7:0]  exp_seq [8];
        exp_seq = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        wr(2'd2, 32'h81);
        checks++; if (leds_export !== 8'h81) begin errors++; $display("FAIL os_seed got %h exp %h", leds_export, 8'h81); end
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hD);
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++; if (leds_export !== exp_seq[i]) begin errors++; $display("FAIL os_step%0d got %h exp %h", i, leds_export, exp_seq[i]); end
        end
        checks++; if (seq_done_irq !== 1'b1) begin errors++; $display("FAIL os_irq got %b exp %b", seq_done_irq, 1'b1); end
        repeat (3) cyc();
        checks++; if (leds_export !== 8'h81) begin errors++; $display("FAIL os_hold got %h exp %h", leds_export, 8'h81); end
        rd(2'd0, d);
        checks++; if (d !== 32'hC) begin errors++; $display("FAIL os_ctrl got %h exp %h", d, 32'hC); end
        rd(2'd3, d);
        checks++; if (d !== 32'h08020081) begin errors++; $display("FAIL os_status got %h exp %h", d, 32'h08020081); end
        wr(2'd3, 32'h0);
        checks++; if (seq_done_irq !== 1'b0) begin errors++; $display("FAIL os_irq_clr got %b exp %b", seq_done_irq, 1'b0); end
        rd(2'd3, d);
        checks++; if (d !== 32'h00000081) begin errors++; $display("FAIL os_status_clr got %h exp %h", d, 32'h00000081); end
    endtask

    task automatic test_blink();
        logic [31:0] d;
        logic [7:0]  exp_seq [7];
        exp_seq = '{8'h5A, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h00};
        wr(2'd2, 32'h5A);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h3);
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++; if (leds_export !== exp_seq[i]) begin errors++; $display("FAIL blink_c%0d got %h exp %h", i + 1, leds_export, exp_seq[i]); end
        end
        // This stop lands on a step cycle, so the step must be dropped.
        wr(2'd0, 32'h0);
        checks++; if (leds_export !== 8'h00) begin errors++; $display("FAIL blink_stop got %h exp %h", leds_export, 8'h00); end
        repeat (4) cyc();
        checks++; if (leds_export !== 8'h00) begin errors++; $display("FAIL blink_freeze got %h exp %h", leds_export, 8'h00); end
        rd(2'd3, d);
        checks++; if (d !== 32'h03000000) begin errors++; $display("FAIL blink_status got %h exp %h", d, 32'h03000000); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        wr(2'd2, 32'h01);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        repeat (2) cyc();
        checks++; if (leds_export !== 8'h02) begin errors++; $display("FAIL col_pre got %h exp %h", leds_export, 8'h02); end
        cyc();
        wr(2'd2, 32'hF0);
        checks++; if (leds_export !== 8'hF0) begin errors++; $display("FAIL col_pat got %h exp %h", leds_export, 8'hF0); end
        rd(2'd3, d);
        checks++; if (d !== 32'h010100F0) begin errors++; $display("FAIL col_pat_cnt got %h exp %h", d, 32'h010100F0); end
        wr(2'd3, 32'h0);
        checks++; if (leds_export !== 8'hE1) begin errors++; $display("FAIL col_st_step got %h exp %h", leds_export, 8'hE1); end
        rd(2'd3, d);
        checks++; if (d !== 32'h000100E1) begin errors++; $display("FAIL col_st_cnt got %h exp %h", d, 32'h000100E1); end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        wr(2'd2, 32'h01);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        rd(2'd3, d);
        checks++; if (d !== 32'h00010001) begin errors++; $display("FAIL mr_status got %h exp %h", d, 32'h00010001); end
        repeat (3) cyc();
        checks++; if (leds_export !== 8'h10) begin errors++; $display("FAIL mr_pre got %h exp %h", leds_export, 8'h10); end
        reset_reset = 1'b1;
        cyc();
        reset_reset = 1'b0;
        $display("reset pulse leds=%h rdata=%h", leds_export, avs_readdata);
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL mr_leds got %h exp %h", leds_export, 8'h01); end
        checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL mr_rdata got %h exp %h", avs_readdata, 32'h0); end
        repeat (5) cyc();
        checks++; if (leds_export !== 8'h01) begin errors++; $display("FAIL mr_idle got %h exp %h", leds_export, 8'h01); end
        rd(2'd3, d);
        checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL mr_st got %h exp %h", d, 32'h00000001); end
        rd(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mr_ctrl got %h exp %h", d, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_read_during_write();
        test_rotate_left();
        test_oneshot_right();
        test_blink();
        test_collisions();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
